rms_result_fifo: RTL and testbench
==================================

Name: rms_result_fifo

Overview:
- Synchronous output FIFO at the tail of the RMS pipeline.
- Buffers 32-bit root results that the sqrt stage pushes with no backpressure.
- Presents them first-word-fall-through to the downstream consumer through a pull/stop handshake.
- Sized to absorb every result in flight in the ~110-stage multiply/divide/sqrt pipeline.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 128, number of storage entries; must be a power of two, at least 2.
- AW, 7, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- pushin  input  1  write strobe; datain is written on this cycle's rising edge
- datain  input  WIDTH  word to store
- dataout  output  WIDTH  head-of-queue word; valid whenever stopout=0
- pullout  input  1  consumer pop request; acted on only when stopout=0
- stopout  output  1  1 = FIFO empty (dataout not valid); 0 = data available

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset state: write pointer = 0, read pointer = 0, count = 0, stopout = 1, dataout = 0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents at that edge.
- Storage is a DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH.
  - count is AW+1 bits, range 0..DEPTH.
- Write: on an edge with pushin=1 and count<DEPTH, mem[wr_ptr] <= datain and wr_ptr advances by 1.
- Read: on an edge with pullout=1 and count>0, rd_ptr advances by 1.
- Count update:
  - +1 on a write only;
  - -1 on a read only;
  - unchanged when both or neither occur.
- First-word-fall-through output:
  - dataout = mem[rd_ptr] combinationally when count>0, else 0.
  - stopout = (count==0), driven from registered state only; no combinational path from pushin or pullout.
- Latency: a word pushed at edge N appears on dataout with stopout=0 immediately after edge N.
  - The consumer may pull it at edge N+1.
- Boundary cases:
  - Pull while empty: ignored; pointers and count unchanged.
  - Push and pull on the same edge while empty: the push is stored, the pull is ignored; count becomes 1.
  - Push while full (count=DEPTH) with no pull: the word is dropped; state unchanged.
  - Push and pull on the same edge while full: both take effect; the new word goes into the freed slot and count stays DEPTH.
  - Push and pull on the same edge with 0<count<DEPTH: both take effect; count unchanged.
  - Pointer wrap: order is preserved across the DEPTH-1 -> 0 transition.
- Ordering: strict first-in first-out; no word is ever duplicated or reordered.

Test Plan:
- Reset then idle -> stopout=1 and dataout=0 every cycle; pullout pulses have no effect.
- Push 0x00000005 at edge 1 -> immediately after edge 1: stopout=0, dataout=0x00000005. Pull at edge 2 -> stopout=1, dataout=0.
- Push 0x1,0x2,0x3 on consecutive edges with pullout=0 -> dataout=0x1. Hold pullout=1 for three edges -> dataout reads 0x2, then 0x3, then stopout=1.
- Continuous push of values 0..199 with pullout held high from the first edge -> consumer receives 0..199 in order with no loss. count never exceeds 1. Pointers wrap past 127.
- Fill with 128 words (0..127), then push 0xDEAD without pulling -> 0xDEAD dropped. Draining all 128 returns 0..127.
- Fill to full, then push 0xBEEF together with a pull -> 0 is popped and count stays 128. The 128th word drained is 0xBEEF.
- Push 3 words, assert rst for one edge -> stopout=1, dataout=0. A following push/pull returns only the new word.

Source files
------------

// File: rtl/rms_result_fifo.sv
// rms_result_fifo
//   Output FIFO at the tail of the RMS pipeline. The sqrt stage pushes 32-bit
//   root results with no backpressure. The consumer sees them
//   first-word-fall-through and removes them with a pull/stop handshake.
//   The depth is chosen to hold every result in flight in the pipeline.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset; discards all contents
//   pushin   write strobe; datain is stored at this edge unless the FIFO is full
//   datain   word to store
//   dataout  head-of-queue word; valid when stopout=0, zero otherwise
//   pullout  pop request; ignored while stopout=1
//   stopout  1 = empty, 0 = dataout holds valid data
module rms_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushin,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  input  logic             pullout,
  output logic             stopout
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // A pull on the same edge frees a slot, so a push into a full FIFO is
  // accepted only when it is paired with a valid pull.
  always_comb begin
    rd_en = pullout && (count != '0);
    wr_en = pushin && ((count != FULL) || rd_en);
  end

  // Storage is not reset; only the pointers and count define the contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outputs depend only on registered state, never on pushin/pullout.
  always_comb begin
    stopout = (count == '0);
    dataout = stopout ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_rms_result_fifo.sv
// tb_rms_result_fifo
//   Drives rms_result_fifo with directed sequences and random push/pull
//   traffic. The expected contents live in a queue: the driver appends
//   each accepted word, and a monitor compares the head against dataout
//   every cycle and removes it when the consumer takes it.
module tb_rms_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic             clk;
  logic             rst;
  logic             pushin;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             pullout;
  logic             stopout;

  logic [WIDTH-1:0] exp_q[$];
  int unsigned      n_total;
  int unsigned      n_pass;

  rms_result_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pushin (pushin),
    .datain (datain),
    .dataout(dataout),
    .pullout(pullout),
    .stopout(stopout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge. The model is updated
  // at the edge itself, so once step returns it matches the DUT state.
  task automatic step(input logic p, input logic [WIDTH-1:0] d,
                      input logic q, input logic r);
    logic acc;
    pushin  = p;
    datain  = d;
    pullout = q;
    rst     = r;
    acc = !r && p && ((exp_q.size() < DEPTH) || (q && exp_q.size() > 0));
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back(d);
    end
    #2;
  endtask

  // Monitor: at the falling edge compare outputs with the model head and
  // note whether this cycle's pull is a real pop; retire the head just
  // after the following rising edge.
  initial begin
    logic take;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("stop_empty", {31'd0, stopout}, 32'd1);
        check("data_empty", dataout, 32'd0);
      end else begin
        check("stop_avail", {31'd0, stopout}, 32'd0);
        check("data_head", dataout, exp_q[0]);
      end
      take = !rst && pullout && !stopout;
      @(posedge clk);
      #1;
      if (take && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    pushin  = 1'b0;
    pullout = 1'b0;
    datain  = '0;
    rst     = 1'b1;

    repeat (2) step(1'b0, '0, 1'b0, 1'b1);
    // Idle with pull pulses: nothing must change.
    for (int i = 0; i < 6; i++) step(1'b0, '0, i[0], 1'b0);
    check("idle_stop", {31'd0, stopout}, 32'd1);
    check("idle_data", dataout, 32'd0);

    // Single word latency.
    step(1'b1, 32'h5, 1'b0, 1'b0);
    check("lat_stop", {31'd0, stopout}, 32'd0);
    check("lat_data", dataout, 32'h5);
    step(1'b0, '0, 1'b1, 1'b0);
    check("lat_pop_stop", {31'd0, stopout}, 32'd1);
    check("lat_pop_data", dataout, 32'd0);

    // Three words, then three pulls.
    for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    check("three_head", dataout, 32'h1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("three_2", dataout, 32'h2);
    step(1'b0, '0, 1'b1, 1'b0);
    check("three_3", dataout, 32'h3);
    step(1'b0, '0, 1'b1, 1'b0);
    check("three_empty", {31'd0, stopout}, 32'd1);

    // Streaming with pull held high; pointers wrap past DEPTH-1.
    for (int i = 0; i < 200; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
    check("stream_last", dataout, 32'd199);
    step(1'b0, '0, 1'b1, 1'b0);
    check("stream_empty", {31'd0, stopout}, 32'd1);

    // Fill, drop on full, drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    check("full_head", dataout, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drop_empty", {31'd0, stopout}, 32'd1);

    // Fill, push together with pull while full, drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hBEEF, 1'b1, 1'b0);
    check("fullpp_head", dataout, 32'd1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("fullpp_last", dataout, 32'hBEEF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("fullpp_empty", {31'd0, stopout}, 32'd1);

    // Push and pull together while empty: push stored, pull ignored.
    step(1'b1, 32'h1234, 1'b1, 1'b0);
    check("emptypp_data", dataout, 32'h1234);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_stop", {31'd0, stopout}, 32'd1);
    check("rst_data", dataout, 32'd0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    check("rst_new", dataout, 32'h77);
    step(1'b0, '0, 1'b1, 1'b0);
    check("rst_new_empty", {31'd0, stopout}, 32'd1);

    // Random traffic, alternating push-heavy and pull-heavy phases so the
    // FIFO visits both full and empty.
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 300; i++) begin
        logic p;
        logic q;
        p = ph[0] ? ($urandom_range(99) < 30) : ($urandom_range(99) < 85);
        q = ph[0] ? ($urandom_range(99) < 85) : ($urandom_range(99) < 30);
        step(p, $urandom, q, ($urandom_range(999) == 0));
      end
    end

    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
